// File: rtl/vscale_dmem_responder.sv
// Word-organised data memory answering the core's two-phase dmem port.
// The address phase is registered; the data phase completes after WAIT_CYCLES stall cycles.
module vscale_dmem_responder #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic        dmem_wait,
  output logic [31:0] dmem_rdata,
  output logic        dmem_badmem_e
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];

  logic          pend;
  logic [3:0]    cnt;
  logic          wen_q;
  logic [2:0]    size_q;
  logic [AW+1:0] addr_q;
  logic          bad_q;

  logic          complete;
  logic          accept;
  logic          out_of_range;
  logic          misaligned;
  logic [3:0]    byte_en;
  logic [AW-1:0] word_idx;

  // Handshake: an address phase is taken on any edge with dmem_en=1 and dmem_wait=0.
  assign dmem_wait    = pend && (cnt != 4'd0);
  assign complete     = pend && (cnt == 4'd0);
  assign accept       = dmem_en && !dmem_wait;
  assign word_idx     = addr_q[AW+1:2];
  assign out_of_range = (dmem_addr >> (AW + 2)) != 32'd0;

  always_comb begin
    misaligned = 1'b0;
    case (dmem_size)
      3'd0:    misaligned = 1'b0;
      3'd1:    misaligned = dmem_addr[0];
      default: misaligned = (dmem_addr[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    byte_en = 4'hF;
    case (size_q)
      3'd0:    byte_en = 4'b0001 << addr_q[1:0];
      3'd1:    byte_en = 4'b0011 << addr_q[1:0];
      default: byte_en = 4'hF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend   <= 1'b0;
      cnt    <= 4'd0;
      wen_q  <= 1'b0;
      size_q <= 3'd0;
      addr_q <= '0;
      bad_q  <= 1'b0;
    end else begin
      if (dmem_wait) cnt <= cnt - 4'd1;
      // A new request may overlap the completion cycle, keeping pend high.
      if (accept) begin
        pend   <= 1'b1;
        cnt    <= 4'(WAIT_CYCLES);
        wen_q  <= dmem_wen;
        size_q <= dmem_size;
        addr_q <= dmem_addr[AW+1:0];
        bad_q  <= out_of_range || misaligned;
      end else if (complete) begin
        pend <= 1'b0;
      end
    end
  end

  // Storage is not reset; a reset edge must never commit a pending store.
  always_ff @(posedge clk) begin
    if (!reset && complete && wen_q && !bad_q) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx][8*i +: 8] <= dmem_wdata_delayed[8*i +: 8];
      end
    end
  end

  assign dmem_rdata    = (complete && !wen_q && !bad_q) ? mem[word_idx] : 32'd0;
  assign dmem_badmem_e = complete && bad_q;

endmodule

// File: tb/tb_vscale_dmem_responder.sv
// Directed bench for vscale_dmem_responder: three instances (0, 2 and 3 wait states)
// checked each cycle against a queue of expected completions.
module tb_vscale_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int EW    = 50;  // {due[15:0], is_load, bad, rdata[31:0]}

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] cyc = 16'd0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  logic [2:0]       en, wen;
  logic [2:0][2:0]  size;
  logic [2:0][31:0] addr, wdata;
  wire  [2:0]       dwait, bad;
  wire  [2:0][31:0] rdata;

  int act = 0;
  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];
  logic [49:0]   wd_q[$];   // {due[15:0], dut[1:0], wdata[31:0]}

  vscale_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .dmem_en(en[0]), .dmem_wen(wen[0]), .dmem_size(size[0]),
    .dmem_addr(addr[0]), .dmem_wdata_delayed(wdata[0]), .dmem_wait(dwait[0]),
    .dmem_rdata(rdata[0]), .dmem_badmem_e(bad[0]));

  vscale_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .dmem_en(en[1]), .dmem_wen(wen[1]), .dmem_size(size[1]),
    .dmem_addr(addr[1]), .dmem_wdata_delayed(wdata[1]), .dmem_wait(dwait[1]),
    .dmem_rdata(rdata[1]), .dmem_badmem_e(bad[1]));

  vscale_dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .dmem_en(en[2]), .dmem_wen(wen[2]), .dmem_size(size[2]),
    .dmem_addr(addr[2]), .dmem_wdata_delayed(wdata[2]), .dmem_wait(dwait[2]),
    .dmem_rdata(rdata[2]), .dmem_badmem_e(bad[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sampled on the falling edge: completions due this cycle, otherwise idle zeros.
  task automatic check_outputs();
    logic [EW-1:0] e;
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        check("rst_wait", 32'(dwait[k]), 32'd0);
        check("rst_rdata", rdata[k], 32'd0);
        check("rst_bad", 32'(bad[k]), 32'd0);
      end
    end else begin
      while (exp_q.size() > 0 && exp_q[0][49:34] < cyc) begin
        e = exp_q.pop_front();
        check("late_completion", 32'(e[49:34]), 32'(cyc));
      end
      if (exp_q.size() > 0 && exp_q[0][49:34] == cyc) begin
        e = exp_q.pop_front();
        check("badmem", 32'(bad[act]), 32'(e[32]));
        if (e[33]) check("rdata", rdata[act], e[31:0]);
      end else begin
        check("idle_rdata", rdata[act], 32'd0);
        check("idle_bad", 32'(bad[act]), 32'd0);
      end
      if (act == 0) check("w0_wait", 32'(dwait[0]), 32'd0);
    end
  endtask

  task automatic step();
    logic [49:0] w;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    while (wd_q.size() > 0 && wd_q[0][49:34] <= cyc) begin
      w = wd_q.pop_front();
      if (w[49:34] == cyc) wdata[w[33:32]] = w[31:0];
    end
  endtask

  task automatic issue(input int k, input logic we, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic exp_bad, input logic [31:0] exp_rd,
                       input int w, input logic track);
    logic [15:0] due;
    due = cyc + 16'd1 + 16'(w);
    en[k] = 1'b1;
    wen[k] = we;
    size[k] = sz;
    addr[k] = a;
    if (we) wd_q.push_back({due, 2'(k), wd});
    if (track) exp_q.push_back({due, !we, exp_bad, exp_rd});
  endtask

  task automatic idle(input int k);
    en[k] = 1'b0;
  endtask

  // One access on a waited instance, inputs held through the wait states.
  task automatic xfer_wait(input int k, input int w, input logic we, input logic [2:0] sz,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic exp_bad, input logic [31:0] exp_rd);
    issue(k, we, sz, a, wd, exp_bad, exp_rd, w, 1'b1);
    for (int i = 0; i < w; i++) begin
      step();
      check("wait_high", 32'(dwait[k]), 32'd1);
    end
    step();
    check("wait_low", 32'(dwait[k]), 32'd0);
    idle(k);
    step();
  endtask

  initial begin
    en = '0; wen = '0; size = '0; addr = '0; wdata = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    // Word store then load, back to back, no wait states.
    act = 0;
    issue(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, 32'd0, 0, 1'b1); step();
    issue(0, 1'b0, 3'd2, 32'h10, 32'd0, 1'b0, 32'hDEADBEEF, 0, 1'b1); step();
    idle(0); step();

    // Lane masking for byte and half stores.
    issue(0, 1'b1, 3'd2, 32'h0, 32'h11223344, 1'b0, 32'd0, 0, 1'b1); step();
    issue(0, 1'b1, 3'd0, 32'h1, 32'hAAAAAAAA, 1'b0, 32'd0, 0, 1'b1); step();
    issue(0, 1'b0, 3'd2, 32'h0, 32'd0, 1'b0, 32'h1122AA44, 0, 1'b1); step();
    issue(0, 1'b1, 3'd1, 32'h2, 32'h55665566, 1'b0, 32'd0, 0, 1'b1); step();
    issue(0, 1'b0, 3'd2, 32'h0, 32'd0, 1'b0, 32'h5566AA44, 0, 1'b1); step();

    // Misaligned and out-of-range accesses flag badmem and change nothing.
    issue(0, 1'b1, 3'd1, 32'h3, 32'hFFFFFFFF, 1'b1, 32'd0, 0, 1'b1); step();
    issue(0, 1'b0, 3'd2, 32'h0, 32'd0, 1'b0, 32'h5566AA44, 0, 1'b1); step();
    issue(0, 1'b0, 3'd2, 32'h1000, 32'd0, 1'b1, 32'd0, 0, 1'b1); step();
    issue(0, 1'b0, 3'd2, 32'h2, 32'd0, 1'b1, 32'd0, 0, 1'b1); step();
    issue(0, 1'b0, 3'd7, 32'h4, 32'd0, 1'b0, 32'hXXXXXXXX, 0, 1'b0); step();
    idle(0); step();

    // Pipelined store/load/load with read-after-write on the same word.
    issue(0, 1'b1, 3'd2, 32'h24, 32'h24242424, 1'b0, 32'd0, 0, 1'b1); step();
    issue(0, 1'b1, 3'd2, 32'h20, 32'h12345678, 1'b0, 32'd0, 0, 1'b1); step();
    issue(0, 1'b1, 3'd2, 32'h20, 32'hCAFEF00D, 1'b0, 32'd0, 0, 1'b1); step();
    issue(0, 1'b0, 3'd2, 32'h20, 32'd0, 1'b0, 32'hCAFEF00D, 0, 1'b1); step();
    issue(0, 1'b0, 3'd2, 32'h24, 32'd0, 1'b0, 32'h24242424, 0, 1'b1); step();
    idle(0); step();
    step();

    // Two wait states: held inputs must not be taken twice.
    act = 1;
    step();
    xfer_wait(1, 2, 1'b1, 3'd2, 32'h10, 32'h0BADF00D, 1'b0, 32'd0);
    xfer_wait(1, 2, 1'b0, 3'd2, 32'h10, 32'd0, 1'b0, 32'h0BADF00D);
    xfer_wait(1, 2, 1'b0, 3'd2, 32'h2000, 32'd0, 1'b1, 32'd0);
    step();

    // Reset in the second wait cycle discards a pending store.
    act = 2;
    step();
    xfer_wait(2, 3, 1'b1, 3'd2, 32'h30, 32'h30303030, 1'b0, 32'd0);
    issue(2, 1'b1, 3'd2, 32'h30, 32'hBBBBBBBB, 1'b0, 32'd0, 3, 1'b0);
    step();
    check("w3_wait_1", 32'(dwait[2]), 32'd1);
    step();
    check("w3_wait_2", 32'(dwait[2]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_wait", 32'(dwait[2]), 32'd0);
    check("async_rst_rdata", rdata[2], 32'd0);
    check("async_rst_bad", 32'(bad[2]), 32'd0);
    idle(2);
    step();
    step();
    step();
    reset = 1'b0;
    step();
    check("post_rst_wait", 32'(dwait[2]), 32'd0);
    xfer_wait(2, 3, 1'b0, 3'd2, 32'h30, 32'd0, 1'b0, 32'h30303030);
    step();
    step();

    check("drain", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
